// File: rtl/alarm_pkg.sv
// rtl/alarm_pkg.sv - shared state encoding and default timing for the alarm sequencer
package alarm_pkg;

   typedef enum logic [2:0] {
      ST_DISARMED   = 3'd0,
      ST_WAIT_OPEN  = 3'd1,
      ST_WAIT_CLOSE = 3'd2,
      ST_ARMING     = 3'd3,
      ST_ARMED      = 3'd4,
      ST_TRIGGERED  = 3'd5,
      ST_SOUNDING   = 3'd6,
      ST_WAIT_CLEAR = 3'd7
   } alarm_state_e;

   localparam int DEF_N_DOORS     = 2;
   localparam int DEF_T_ARM       = 6;
   localparam int DEF_T_DRIVER    = 8;
   localparam int DEF_T_PASSENGER = 15;
   localparam int DEF_T_SIREN     = 10;
   localparam int DEF_CW          = 8;

   function automatic logic is_counting(input alarm_state_e s);
      return (s == ST_ARMING) || (s == ST_TRIGGERED) || (s == ST_SOUNDING);
   endfunction

endpackage

// File: rtl/countdown_timer.sv
// rtl/countdown_timer.sv - tick-driven down counter; clear beats load beats decrement
module countdown_timer #(
   parameter int CW = 8
) (
   input  logic          clock,
   input  logic          reset,
   input  logic          load,
   input  logic [CW-1:0] load_val,
   input  logic          clear,
   input  logic          tick,
   output logic [CW-1:0] value,
   output logic          expire
);

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         value <= '0;
      end else if (clear) begin
         value <= '0;
      end else if (load) begin
         value <= load_val;
      end else if (tick && (value != '0)) begin
         value <= value - 1'b1;
      end
   end

   assign expire = tick && (value == CW'(1));

endmodule

// File: rtl/alarm_sequencer.sv
// rtl/alarm_sequencer.sv - arm/disarm sequencer with entry delays, timed siren and status LED
module alarm_sequencer
   import alarm_pkg::*;
#(
   parameter int N_DOORS     = DEF_N_DOORS,
   parameter int T_ARM       = DEF_T_ARM,
   parameter int T_DRIVER    = DEF_T_DRIVER,
   parameter int T_PASSENGER = DEF_T_PASSENGER,
   parameter int T_SIREN     = DEF_T_SIREN,
   parameter int CW          = DEF_CW
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               en,
   input  logic               tick,
   input  logic               ignition,
   input  logic [N_DOORS-1:0] door,
   output logic [2:0]         state,
   output logic               siren,
   output logic               status_led,
   output logic               count_active,
   output logic [CW-1:0]      count_value
);

   alarm_state_e  state_q, state_next;
   logic          led_q, led_next;
   logic          tmr_load, tmr_clear, tmr_tick, tmr_expire;
   logic [CW-1:0] tmr_load_val;
   logic          any_open;

   assign any_open = |door;
   // The timer only sees ticks while a count-down is actually running.
   assign tmr_tick = tick && is_counting(state_q);

   countdown_timer #(.CW(CW)) u_timer (
      .clock    (clock),
      .reset    (reset),
      .load     (tmr_load),
      .load_val (tmr_load_val),
      .clear    (tmr_clear),
      .tick     (tmr_tick),
      .value    (count_value),
      .expire   (tmr_expire)
   );

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q <= ST_DISARMED;
         led_q   <= 1'b0;
      end else begin
         state_q <= state_next;
         led_q   <= led_next;
      end
   end

   always_comb begin
      state_next   = state_q;
      tmr_load     = 1'b0;
      tmr_load_val = '0;
      tmr_clear    = 1'b0;
      led_next     = 1'b0;

      if (!en || ignition) begin
         state_next = ST_DISARMED;
         tmr_clear  = 1'b1;
      end else begin
         case (state_q)
            ST_DISARMED:   state_next = ST_WAIT_OPEN;
            ST_WAIT_OPEN:  if (door[0]) state_next = ST_WAIT_CLOSE;
            ST_WAIT_CLOSE: begin
               if (!any_open) begin
                  state_next   = ST_ARMING;
                  tmr_load     = 1'b1;
                  tmr_load_val = CW'(T_ARM);
               end
            end
            ST_ARMING: begin
               if (any_open) begin
                  state_next = ST_WAIT_CLOSE;
                  tmr_clear  = 1'b1;
               end else if (tmr_expire) begin
                  state_next = ST_ARMED;
               end
            end
            ST_ARMED: begin
               if (any_open) begin
                  state_next   = ST_TRIGGERED;
                  tmr_load     = 1'b1;
                  tmr_load_val = door[0] ? CW'(T_DRIVER) : CW'(T_PASSENGER);
               end
            end
            ST_TRIGGERED: begin
               if (tmr_expire) begin
                  state_next   = ST_SOUNDING;
                  tmr_load     = 1'b1;
                  tmr_load_val = CW'(T_SIREN);
               end
            end
            ST_SOUNDING:   if (tmr_expire) state_next = ST_WAIT_CLEAR;
            ST_WAIT_CLEAR: if (!any_open) state_next = ST_ARMED;
            default:       state_next = ST_DISARMED;
         endcase
      end

      // Entering ARMED lights the LED; afterwards each tick toggles it.
      case (state_next)
         ST_ARMED:     led_next = (state_q != ST_ARMED) ? 1'b1 : (tick ? ~led_q : led_q);
         ST_ARMING,
         ST_TRIGGERED,
         ST_SOUNDING:  led_next = 1'b1;
         default:      led_next = 1'b0;
      endcase
   end

   assign state        = state_q;
   assign siren        = (state_q == ST_SOUNDING);
   assign count_active = is_counting(state_q);
   assign status_led   = led_q;

endmodule

// File: tb/tb_alarm_sequencer.sv
// tb/tb_alarm_sequencer.sv - scoreboard bench for alarm_sequencer with directed vectors
module tb_alarm_sequencer;
   import alarm_pkg::*;

   typedef struct {
      string        name;
      alarm_state_e st;
      logic         siren;
      logic         led;
      logic         active;
      logic [7:0]   value;
   } exp_t;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic       en = 1'b1;
   logic       tick = 1'b0;
   logic       ignition = 1'b1;
   logic [1:0] door = 2'b00;
   logic [2:0] state;
   logic       siren, status_led, count_active;
   logic [7:0] count_value;

   exp_t sb[$];
   event chk_now;
   int   n_tests = 0;
   int   n_fail = 0;

   alarm_sequencer #(
      .N_DOORS(2), .T_ARM(3), .T_DRIVER(2), .T_PASSENGER(4), .T_SIREN(2), .CW(8)
   ) dut (
      .clock        (clock),
      .reset        (reset),
      .en           (en),
      .tick         (tick),
      .ignition     (ignition),
      .door         (door),
      .state        (state),
      .siren        (siren),
      .status_led   (status_led),
      .count_active (count_active),
      .count_value  (count_value)
   );

   always #5 clock = ~clock;

   task automatic push_exp(input string nm, input alarm_state_e st, input logic led,
                           input logic [7:0] val);
      exp_t e;
      e.name   = nm;
      e.st     = st;
      e.siren  = (st == ST_SOUNDING);
      e.active = (st == ST_ARMING) || (st == ST_TRIGGERED) || (st == ST_SOUNDING);
      e.led    = led;
      e.value  = val;
      sb.push_back(e);
   endtask

   task automatic check(input string nm, input string fld, input int act, input int req);
      n_tests++;
      if (act != req) begin
         n_fail++;
         $display("FAIL %s.%s: got %0d, expected %0d", nm, fld, act, req);
      end
   endtask

   // Monitor: compares whatever expectation is pending shortly after each edge
   // (or after an asynchronous event flagged by chk_now).
   initial begin
      exp_t e;
      forever begin
         @(posedge clock or chk_now);
         #2;
         if (sb.size() > 0) begin
            e = sb.pop_front();
            check(e.name, "state", int'(state), int'(e.st));
            check(e.name, "siren", int'(siren), int'(e.siren));
            check(e.name, "led", int'(status_led), int'(e.led));
            check(e.name, "active", int'(count_active), int'(e.active));
            check(e.name, "count", int'(count_value), int'(e.value));
         end
      end
   end

   task automatic cyc(input logic e_n, input logic ign, input logic [1:0] d, input logic tk,
                      input alarm_state_e st, input logic led, input logic [7:0] val,
                      input string nm);
      @(negedge clock);
      en       = e_n;
      ignition = ign;
      door     = d;
      tick     = tk;
      push_exp(nm, st, led, val);
   endtask

   task automatic arm_from_disarmed();
      cyc(1, 0, 2'b00, 0, ST_WAIT_OPEN, 0, 0, "re_wait_open");
      cyc(1, 0, 2'b01, 0, ST_WAIT_CLOSE, 0, 0, "re_wait_close");
      cyc(1, 0, 2'b00, 0, ST_ARMING, 1, 3, "re_arm_load");
      cyc(1, 0, 2'b00, 1, ST_ARMING, 1, 2, "re_arm_t1");
      cyc(1, 0, 2'b00, 1, ST_ARMING, 1, 1, "re_arm_t2");
      cyc(1, 0, 2'b00, 1, ST_ARMED, 1, 0, "re_armed");
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset state while reset is held
      @(negedge clock);
      push_exp("reset_hold", ST_DISARMED, 0, 0);
      -> chk_now;
      @(negedge clock);
      reset = 1'b0;
      cyc(1, 1, 2'b00, 0, ST_DISARMED, 0, 0, "ign_hold");

      // 1. Arming
      cyc(1, 0, 2'b00, 0, ST_WAIT_OPEN, 0, 0, "to_wait_open");
      cyc(1, 0, 2'b10, 1, ST_WAIT_OPEN, 0, 0, "wo_pass_ignored");
      cyc(1, 0, 2'b01, 0, ST_WAIT_CLOSE, 0, 0, "drv_open");
      cyc(1, 0, 2'b00, 1, ST_ARMING, 1, 3, "arm_load_tick_ignored");
      cyc(1, 0, 2'b00, 1, ST_ARMING, 1, 2, "arm_t1");
      cyc(1, 0, 2'b00, 0, ST_ARMING, 1, 2, "arm_idle");
      cyc(1, 0, 2'b00, 1, ST_ARMING, 1, 1, "arm_t2");
      // 2. Arming abort and reload
      cyc(1, 0, 2'b10, 1, ST_WAIT_CLOSE, 0, 0, "arm_abort");
      cyc(1, 0, 2'b00, 0, ST_ARMING, 1, 3, "arm_reload");
      cyc(1, 0, 2'b00, 1, ST_ARMING, 1, 2, "arm2_t1");
      cyc(1, 0, 2'b00, 1, ST_ARMING, 1, 1, "arm2_t2");
      cyc(1, 0, 2'b00, 1, ST_ARMED, 1, 0, "armed");
      cyc(1, 0, 2'b00, 1, ST_ARMED, 0, 0, "led_t1");
      cyc(1, 0, 2'b00, 0, ST_ARMED, 0, 0, "led_hold");
      cyc(1, 0, 2'b00, 1, ST_ARMED, 1, 0, "led_t2");

      // 3. Driver entry then ignition
      cyc(1, 0, 2'b01, 1, ST_TRIGGERED, 1, 2, "drv_trig");
      cyc(1, 0, 2'b10, 1, ST_TRIGGERED, 1, 1, "drv_trig_t1");
      cyc(1, 1, 2'b00, 0, ST_DISARMED, 0, 0, "ign_disarm");
      arm_from_disarmed();

      // 4. Passenger intrusion through siren and clear
      cyc(1, 0, 2'b10, 0, ST_TRIGGERED, 1, 4, "pass_trig");
      cyc(1, 0, 2'b10, 1, ST_TRIGGERED, 1, 3, "pass_t1");
      cyc(1, 0, 2'b00, 1, ST_TRIGGERED, 1, 2, "pass_t2");
      cyc(1, 0, 2'b00, 1, ST_TRIGGERED, 1, 1, "pass_t3");
      cyc(1, 0, 2'b00, 1, ST_SOUNDING, 1, 2, "sounding");
      cyc(1, 0, 2'b00, 1, ST_SOUNDING, 1, 1, "sound_t1");
      cyc(1, 0, 2'b10, 1, ST_WAIT_CLEAR, 0, 0, "wait_clear");
      cyc(1, 0, 2'b10, 0, ST_WAIT_CLEAR, 0, 0, "wc_hold");
      cyc(1, 0, 2'b00, 1, ST_ARMED, 1, 0, "rearmed");

      // 5. Simultaneous doors with a tick
      cyc(1, 0, 2'b11, 1, ST_TRIGGERED, 1, 2, "simul");
      cyc(1, 0, 2'b00, 1, ST_TRIGGERED, 1, 1, "simul_t1");
      cyc(1, 0, 2'b00, 1, ST_SOUNDING, 1, 2, "simul_sound");

      // 6. Enable override, then asynchronous reset mid-count
      cyc(0, 0, 2'b00, 1, ST_DISARMED, 0, 0, "en_low");
      cyc(0, 0, 2'b01, 1, ST_DISARMED, 0, 0, "en_low_hold");
      cyc(1, 0, 2'b00, 0, ST_WAIT_OPEN, 0, 0, "en_restore");
      cyc(1, 0, 2'b01, 0, ST_WAIT_CLOSE, 0, 0, "en_wait_close");
      cyc(1, 0, 2'b00, 0, ST_ARMING, 1, 3, "en_arm_load");
      cyc(1, 0, 2'b00, 1, ST_ARMING, 1, 2, "en_arm_t1");
      cyc(1, 0, 2'b00, 1, ST_ARMING, 1, 1, "en_arm_t2");
      cyc(1, 0, 2'b00, 1, ST_ARMED, 1, 0, "en_armed");
      cyc(1, 0, 2'b10, 0, ST_TRIGGERED, 1, 4, "rst_trig");
      cyc(1, 0, 2'b00, 1, ST_TRIGGERED, 1, 3, "rst_trig_t1");
      @(negedge clock);
      #1;
      reset = 1'b1;
      tick  = 1'b0;
      push_exp("async_reset", ST_DISARMED, 0, 0);
      -> chk_now;
      @(negedge clock);
      ignition = 1'b1;
      reset    = 1'b0;
      cyc(1, 0, 2'b00, 0, ST_WAIT_OPEN, 0, 0, "post_reset");

      for (int i = 0; i < 5 && sb.size() > 0; i++) @(posedge clock);
      #3;
      if (sb.size() > 0) begin
         n_tests++;
         n_fail++;
         $display("FAIL drain: %0d expectations pending, expected 0", sb.size());
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/alarm_sequencer.md
Name: alarm_sequencer

Overview:
Parametrised arm/disarm sequencer for the vehicle alarm. It generalises the door-triggered count-down to N doors, with an internal count-down timer driven by an external 1 Hz tick. It adds automatic arming after the driver leaves, separate entry delays for the driver and passenger doors, and a time-limited siren. It sits between the door/ignition sensor conditioning and the siren and status-LED drivers.

Parameters:
N_DOORS, 2, number of door inputs; bit 0 is the driver door, all other bits are passenger/other doors (N_DOORS >= 1).
T_ARM, 6, ticks from all doors closed to ARMED (>= 1).
T_DRIVER, 8, entry delay in ticks when the driver door triggers (>= 1).
T_PASSENGER, 15, entry delay in ticks when only non-driver doors trigger (>= 1).
T_SIREN, 10, siren duration in ticks (>= 1).
CW, 8, count-down width; must hold the largest T_* value.

Ports:
clock  in  1  system clock; all logic on the rising edge.
reset  in  1  asynchronous, active-high; forces every register to its reset value.
en  in  1  synchronous enable; when low, state goes to DISARMED on the next edge.
tick  in  1  one-clock pulse at 1 Hz; the only timebase for counting.
ignition  in  1  high = ignition on (disarm request).
door  in  N_DOORS  high = door open.
state  out  3  current state encoding, from the shared package.
siren  out  1  siren drive.
status_led  out  1  dash LED.
count_active  out  1  high while the count-down is running (ARMING, TRIGGERED, SOUNDING).
count_value  out  CW  remaining ticks.

Behaviour:
- States: DISARMED, WAIT_OPEN, WAIT_CLOSE, ARMING, ARMED, TRIGGERED, SOUNDING, WAIT_CLEAR.
- Reset values: state=DISARMED, siren=0, status_led=0, count_active=0, count_value=0.
- All outputs are Moore outputs, decoded from registered state, counter and LED flop. There is no combinational input-to-output path.
- Priority per edge, highest first: reset, en==0, ignition==1, door events, timer expiry.
- en==0 -> DISARMED and count_value=0. This holds regardless of the other inputs.
- ignition==1 in any state -> DISARMED next edge and count_value cleared. If ignition stays high, the state stays DISARMED.
- DISARMED: ignition==0 -> WAIT_OPEN.
- WAIT_OPEN: door[0]==1 -> WAIT_CLOSE.
- WAIT_CLOSE: door==0 (all closed) -> ARMING, loading count_value=T_ARM.
- ARMING: any door open -> WAIT_CLOSE, count cleared. Otherwise, a tick with count_value==1 -> ARMED with count 0. Any other tick decrements the count.
- ARMED: any door open -> TRIGGERED.
  - Load T_DRIVER if door[0]==1, else T_PASSENGER.
  - Driver and passenger opening on the same edge loads T_DRIVER.
- TRIGGERED:
  - Further door changes are ignored.
  - A tick with count_value==1 -> SOUNDING, loading T_SIREN.
  - Otherwise a tick decrements the count.
- SOUNDING: siren=1. A tick with count_value==1 -> WAIT_CLEAR with count 0.
- WAIT_CLEAR: siren=0. door==0 -> ARMED on the next edge.
- Timing rule: exactly T ticks elapse from load to the expiry transition. The expiry edge is the edge on which the T-th tick is sampled. Ticks arriving on the load edge are not counted.
- count_active=1 in ARMING, TRIGGERED and SOUNDING; 0 elsewhere.
- status_led:
  - 0 in DISARMED, WAIT_OPEN, WAIT_CLOSE and WAIT_CLEAR.
  - 1 in ARMING, TRIGGERED and SOUNDING.
  - In ARMED it toggles on every tick, and it enters ARMED at 1.
- Reset asserted mid-count clears everything asynchronously. After release, the block restarts from DISARMED.

Decomposition:
- Package alarm_pkg holds the state encoding constants (3-bit) and the default T_* values.
- Sub-module countdown_timer (parameter CW) provides:
  - inputs: load, load_val, clear, tick
  - outputs: value, expire
  - expire is a combinational tick && value==1.
- The sequencer FSM and the LED flop live in alarm_sequencer.

Test Plan:
Use T_ARM=3, T_DRIVER=2, T_PASSENGER=4, T_SIREN=2, N_DOORS=2.
1. Arming: ignition 1->0, door=01, then door=00, then 3 ticks -> ARMED on the 3rd tick edge; count_value 3,2,1,0; status_led toggles 1,0,... on later ticks.
2. Arming abort: in ARMING after 2 ticks set door=10 -> WAIT_CLOSE with count_value=0; close the door -> ARMING reloaded with 3.
3. Driver entry: from ARMED set door=01 -> TRIGGERED with count_value=2; ignition=1 before the 2nd tick -> DISARMED, siren never asserted.
4. Passenger intrusion: from ARMED set door=10 -> TRIGGERED with 4; after 4 ticks SOUNDING (siren=1); after 2 ticks WAIT_CLEAR (siren=0); door=00 -> ARMED.
5. Simultaneous: door=11 on the same edge as a tick in ARMED -> TRIGGERED with count_value=2, not decremented.
6. Overrides: en=0 in SOUNDING -> DISARMED and siren=0 next edge; reset pulse mid-TRIGGERED -> all outputs 0 immediately (asynchronously).
